// File: rtl/reg_writeback_unit_if.sv
// Writeback request channel from the memory/ALU stage into reg_writeback_unit.
// The producer drives the request fields; the writeback unit returns ready.
interface reg_writeback_unit_if;
  logic        valid;
  logic        ready;
  logic [5:0]  opcode;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        regdst;
  logic [31:0] data;

  modport master (output valid, opcode, rt, rd, regdst, data, input ready);
  modport slave  (input valid, opcode, rt, rd, regdst, data, output ready);
endinterface

// File: rtl/reg_writeback_unit.sv
// Buffers writeback requests in a FIFO, merges LBU/LHU results with the old
// register value, and issues one full-width register write per request.
module reg_writeback_unit #(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  reg_writeback_unit_if.slave wb,
  output logic [4:0]          rf_raddr,
  input  logic [31:0]         rf_rdata,
  output logic                reg_write,
  output logic [4:0]          reg_waddr,
  output logic [31:0]         reg_wdata,
  output logic [31:0]         busy_mask,
  output logic                empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  logic [1:0]  size_mem [DEPTH];
  logic [4:0]  dest_mem [DEPTH];
  logic [31:0] data_mem [DEPTH];

  logic [AW:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
  logic        ready_q;
  logic [1:0]  state;
  logic        push, pop, fifo_empty;
  logic [1:0]  push_size;
  logic [4:0]  push_dest;
  logic [1:0]  head_size;
  logic [4:0]  head_dest;
  logic [31:0] head_data;
  logic        inc, dec;
  logic [CW-1:0] pend_cnt  [32];
  logic [CW-1:0] pend_next [32];

  function automatic logic [31:0] merge_data(input logic [1:0] sz,
                                             input logic [31:0] old,
                                             input logic [31:0] d);
    case (sz)
      SZ_BYTE: merge_data = {old[31:8], d[7:0]};
      SZ_HALF: merge_data = {old[31:16], d[15:0]};
      default: merge_data = d;
    endcase
  endfunction

  assign wb.ready   = ready_q;
  assign push       = wb.valid && ready_q;
  assign pop        = (state == ST_WRITE);
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign push_dest  = wb.regdst ? wb.rd : wb.rt;

  always_comb begin
    push_size = SZ_WORD;
    case (wb.opcode)
      6'h24:   push_size = SZ_BYTE;
      6'h25:   push_size = SZ_HALF;
      default: push_size = SZ_WORD;
    endcase
  end

  assign head_size = size_mem[rd_ptr[AW-1:0]];
  assign head_dest = dest_mem[rd_ptr[AW-1:0]];
  assign head_data = data_mem[rd_ptr[AW-1:0]];

  assign wr_ptr_next = wr_ptr + {{AW{1'b0}}, push};
  assign rd_ptr_next = rd_ptr + {{AW{1'b0}}, pop};

  // Ready is precomputed from next-cycle occupancy so it never depends on this cycle's pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ready_q <= 1'b1;
    end else begin
      wr_ptr  <= wr_ptr_next;
      rd_ptr  <= rd_ptr_next;
      ready_q <= ((wr_ptr_next ^ rd_ptr_next) != {1'b1, {AW{1'b0}}});
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      size_mem[wr_ptr[AW-1:0]] <= push_size;
      dest_mem[wr_ptr[AW-1:0]] <= push_dest;
      data_mem[wr_ptr[AW-1:0]] <= wb.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      reg_write <= 1'b0;
      reg_waddr <= '0;
      reg_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          reg_write <= 1'b0;
          if (!fifo_empty) begin
            reg_waddr <= head_dest;
            if (head_size == SZ_WORD) begin
              state     <= ST_WRITE;
              reg_write <= (head_dest != 5'd0);
              reg_wdata <= head_data;
            end else begin
              state <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          // rf_rdata reflects every earlier queued write, since those completed in order.
          state     <= ST_WRITE;
          reg_write <= (head_dest != 5'd0);
          reg_wdata <= merge_data(head_size, rf_rdata, head_data);
        end
        ST_WRITE: begin
          state     <= ST_IDLE;
          reg_write <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          reg_write <= 1'b0;
        end
      endcase
    end
  end

  assign rf_raddr = head_dest;
  assign empty    = fifo_empty && (state == ST_IDLE);

  assign inc = push && (push_dest != 5'd0);
  assign dec = pop && (head_dest != 5'd0);

  // Pending counts let several queued writes to one register keep it busy.
  always_comb begin
    for (int n = 0; n < 32; n++) begin
      pend_next[n] = pend_cnt[n];
      if (inc && (push_dest == 5'(n))) pend_next[n] = pend_next[n] + CW'(1);
      if (dec && (head_dest == 5'(n))) pend_next[n] = pend_next[n] - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < 32; n++) begin
      pend_cnt[n] <= rst ? '0 : pend_next[n];
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int n = 0; n < 32; n++) begin
      busy_mask[n] = (pend_cnt[n] != '0);
    end
  end

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Self-checking bench for reg_writeback_unit: directed vector table, corner
// sequences, and a randomized run against a register-file model with scoreboard.
module tb_reg_writeback_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        reg_write;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic [31:0] busy_mask;
  logic        empty;

  always #5 clk = ~clk;

  reg_writeback_unit_if wb_bus ();

  reg_writeback_unit #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb        (wb_bus),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .reg_write (reg_write),
    .reg_waddr (reg_waddr),
    .reg_wdata (reg_wdata),
    .busy_mask (busy_mask),
    .empty     (empty)
  );

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        regdst;
    logic [31:0] data;
    logic [31:0] old;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  logic [31:0] rf     [32] = '{default: 32'h0};
  logic [31:0] shadow [32] = '{default: 32'h0};
  logic        preload_en = 1'b0;
  logic [4:0]  preload_addr = '0;
  logic [31:0] preload_data = '0;

  wr_t sb[$];
  wr_t mon_e;
  bit  flush_sb = 1'b0;
  bit  saw_not_ready = 1'b0;
  int  total = 0;
  int  bad = 0;
  int  writes_seen = 0;
  int  addr_writes [32] = '{default: 0};

  // Register-file model feeding the merge read port.
  assign rf_rdata = rf[rf_raddr];

  always @(posedge clk) begin
    if (preload_en) rf[preload_addr] <= preload_data;
    else if (reg_write) rf[reg_waddr] <= reg_wdata;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] modelMerge(input logic [5:0] op, input logic [31:0] old,
                                             input logic [31:0] d);
    if (op == 6'h24) return {old[31:8], d[7:0]};
    if (op == 6'h25) return {old[31:16], d[15:0]};
    return d;
  endfunction

  // Every strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (flush_sb) sb.delete();
    if (reg_write) begin
      writes_seen++;
      addr_writes[reg_waddr]++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_strobe", {27'd0, reg_waddr}, 32'hFFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("sb_addr", {27'd0, reg_waddr}, {27'd0, mon_e.addr});
        checkOutput("sb_data", reg_wdata, mon_e.data);
      end
    end
  end

  task automatic preloadReg(input logic [4:0] a, input logic [31:0] d);
    preload_en   = 1'b1;
    preload_addr = a;
    preload_data = d;
    shadow[a]    = d;
    @(posedge clk);
    #1;
    preload_en = 1'b0;
  endtask

  // Holds the request until accepted; returns #1 after the accept edge.
  task automatic applyStimulus(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rd,
                               input logic regdst, input logic [31:0] data);
    logic       acc;
    logic [4:0] dst;
    wr_t        e;
    int         waited;
    wb_bus.valid  = 1'b1;
    wb_bus.opcode = op;
    wb_bus.rt     = rt;
    wb_bus.rd     = rd;
    wb_bus.regdst = regdst;
    wb_bus.data   = data;
    acc    = 1'b0;
    waited = 0;
    while (!acc && waited < 100) begin
      @(negedge clk);
      acc = wb_bus.ready;
      if (!acc) saw_not_ready = 1'b1;
      @(posedge clk);
      #1;
      waited++;
    end
    wb_bus.valid = 1'b0;
    if (!acc) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
    end else begin
      dst = regdst ? rd : rt;
      if (dst != 5'd0) begin
        shadow[dst] = modelMerge(op, shadow[dst], data);
        e.addr = dst;
        e.data = shadow[dst];
        sb.push_back(e);
      end
    end
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (!(empty && sb.size() == 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(name, 32'(n >= 200), 32'd0);
  endtask

  vec_t vecs [7];

  initial begin
    int lat;
    int base;
    int base9;
    logic [31:0] save4, save6;
    logic [5:0]  rop;
    logic [4:0]  rrt, rrd;

    vecs[0] = '{6'h23, 5'd5,  5'd0,  1'b0, 32'hDEADBEEF, 32'h00000000, 5'd5,  32'hDEADBEEF, 2};
    vecs[1] = '{6'h24, 5'd0,  5'd7,  1'b1, 32'h000000AA, 32'h11223344, 5'd7,  32'h112233AA, 3};
    vecs[2] = '{6'h25, 5'd0,  5'd7,  1'b1, 32'h0000BBBB, 32'h11223344, 5'd7,  32'h1122BBBB, 3};
    vecs[3] = '{6'h24, 5'd12, 5'd3,  1'b0, 32'hFFFFFF5A, 32'hCAFEF00D, 5'd12, 32'hCAFEF05A, 3};
    vecs[4] = '{6'h25, 5'd1,  5'd31, 1'b1, 32'h12348001, 32'h0F0F0F0F, 5'd31, 32'h0F0F8001, 3};
    vecs[5] = '{6'h00, 5'd2,  5'd3,  1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd3,  32'h80000000, 2};
    vecs[6] = '{6'h3F, 5'd20, 5'd21, 1'b0, 32'h0000007F, 32'h55555555, 5'd20, 32'h0000007F, 2};

    rst           = 1'b1;
    wb_bus.valid  = 1'b0;
    wb_bus.opcode = '0;
    wb_bus.rt     = '0;
    wb_bus.rd     = '0;
    wb_bus.regdst = 1'b0;
    wb_bus.data   = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready", 32'(wb_bus.ready), 32'd1);
    checkOutput("rst_reg_write", 32'(reg_write), 32'd0);
    checkOutput("rst_waddr", {27'd0, reg_waddr}, 32'd0);
    checkOutput("rst_wdata", reg_wdata, 32'd0);
    checkOutput("rst_busy", busy_mask, 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    rst = 1'b0;

    // Single requests: latency, merge result and busy lifetime.
    for (int i = 0; i < 7; i++) begin
      preloadReg(vecs[i].exp_addr, vecs[i].old);
      applyStimulus(vecs[i].op, vecs[i].rt, vecs[i].rd, vecs[i].regdst, vecs[i].data);
      checkOutput($sformatf("v%0d_busy_set", i), 32'(busy_mask[vecs[i].exp_addr]), 32'd1);
      lat = 1;
      while (!reg_write && lat < 10) begin
        @(posedge clk);
        #1;
        lat++;
      end
      checkOutput($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      checkOutput($sformatf("v%0d_addr", i), {27'd0, reg_waddr}, {27'd0, vecs[i].exp_addr});
      checkOutput($sformatf("v%0d_data", i), reg_wdata, vecs[i].exp_data);
      checkOutput($sformatf("v%0d_busy_in_write", i), 32'(busy_mask[vecs[i].exp_addr]), 32'd1);
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d_strobe_one_cycle", i), 32'(reg_write), 32'd0);
      checkOutput($sformatf("v%0d_busy_clear", i), busy_mask, 32'd0);
      checkOutput($sformatf("v%0d_empty", i), 32'(empty), 32'd1);
    end

    // Back-to-back burst outruns the drain rate and must hit backpressure.
    saw_not_ready = 1'b0;
    base = writes_seen;
    for (int k = 0; k < 2 * DEPTH; k++) begin
      applyStimulus(6'h23, 5'(10 + k), 5'd0, 1'b0, 32'hA000_0000 + 32'(k));
    end
    waitIdle("burst_drain");
    checkOutput("burst_backpressure", 32'(saw_not_ready), 32'd1);
    checkOutput("burst_write_count", writes_seen - base, 2 * DEPTH);

    // Two writes to r9 keep it busy until the second completes; r0 is silent.
    base9 = addr_writes[9];
    base  = writes_seen;
    applyStimulus(6'h23, 5'd9, 5'd0, 1'b0, 32'h9999_0001);
    applyStimulus(6'h24, 5'd9, 5'd0, 1'b0, 32'h9999_0002);
    applyStimulus(6'h23, 5'd0, 5'd0, 1'b0, 32'h1234_5678);
    for (int c = 0; c < 20 && !empty; c++) begin
      checkOutput("r9_busy", 32'(busy_mask[9]), 32'((addr_writes[9] - base9) < 2));
      checkOutput("r0_busy", 32'(busy_mask[0]), 32'd0);
      @(posedge clk);
      #1;
    end
    waitIdle("r9_drain");
    checkOutput("r9_writes", addr_writes[9] - base9, 32'd2);
    checkOutput("r0_no_strobe", addr_writes[0], 32'd0);
    checkOutput("r9_value", rf[9], 32'h9999_0002);
    checkOutput("r9_r0_total_writes", writes_seen - base, 32'd2);

    // Reset while the head partial write is in FETCH with a second entry queued.
    save4 = shadow[4];
    save6 = shadow[6];
    preloadReg(5'd4, 32'h4444_4444);
    save4 = shadow[4];
    applyStimulus(6'h24, 5'd4, 5'd0, 1'b0, 32'h0000_00EE);
    applyStimulus(6'h23, 5'd6, 5'd0, 1'b0, 32'h6666_6666);
    base     = writes_seen;
    rst      = 1'b1;
    flush_sb = 1'b1;
    checkOutput("rst_mid_busy_before", busy_mask & 32'h50, 32'h50);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    flush_sb = 1'b0;
    shadow[4] = save4;
    shadow[6] = save6;
    checkOutput("rst_mid_reg_write", 32'(reg_write), 32'd0);
    checkOutput("rst_mid_busy", busy_mask, 32'd0);
    checkOutput("rst_mid_empty", 32'(empty), 32'd1);
    checkOutput("rst_mid_ready", 32'(wb_bus.ready), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("rst_mid_no_writes", writes_seen - base, 32'd0);
    checkOutput("rst_mid_r4_kept", rf[4], 32'h4444_4444);

    // Random mix against the register model.
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 2))
        0: rop = 6'h24;
        1: rop = 6'h25;
        default: begin
          rop = 6'($urandom_range(0, 63));
          if (rop == 6'h24 || rop == 6'h25) rop = 6'h23;
        end
      endcase
      rrt = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      rrd = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      applyStimulus(rop, rrt, rrd, 1'($urandom_range(0, 1)), $urandom);
    end
    waitIdle("random_drain");
    for (int r = 0; r < 32; r++) begin
      checkOutput($sformatf("final_r%0d", r), rf[r], shadow[r]);
    end
    checkOutput("sb_leftover", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
